mlp_weight_sequencer: RTL and testbench



---
 rtl/mlp_weight_sequencer_pkg.sv | 28 ++
 rtl/mlp_outstanding_counter.sv | 33 +++
 rtl/mlp_weight_sequencer.sv | 140 ++++++++++++++
 tb/tb_mlp_weight_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_weight_sequencer_pkg.sv
`default_nettype none
// mlp_weight_sequencer_pkg: shared state encoding and store geometry for the MLP weight sequencer.
// Revision 1.0
package mlp_weight_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_RDY = 3'd1,
    ST_L1_ISSUE = 3'd2,
    ST_L1_DRAIN = 3'd3,
    ST_L2_ISSUE = 3'd4,
    ST_L2_DRAIN = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  localparam int W1_ADDR_W  = 5;
  localparam int W2_ADDR_W  = 3;
  localparam int B1_ADDR_W  = 2;
  localparam int B2_ADDR_W  = 1;
  localparam int BIAS_BYTES = 8;
  localparam int BIAS_SEL_W = $clog2(BIAS_BYTES);
  localparam int W1_ROWS    = 32;
  localparam int W2_ROWS    = 8;
  localparam int B1_WORDS   = 4;
  localparam int B2_WORDS   = 2;

endpackage
`default_nettype wire

// File: rtl/mlp_outstanding_counter.sv
`default_nettype none
// mlp_outstanding_counter: saturating up/down count of jobs in flight, flags a decrement at zero.
// Revision 1.0
module mlp_outstanding_counter #(
  parameter int MAX = 2,
  parameter int W   = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         underflow
);

  // A completion with nothing in flight cannot belong to any accepted job.
  assign underflow = dec && (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !dec) begin
      if (count != W'(MAX)) count <= count + W'(1);
    end else if (dec && !inc) begin
      if (count != '0) count <= count - W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mlp_weight_sequencer.sv
`default_nettype none
// mlp_weight_sequencer: walks W1/B1 then W2/B2 one neuron job per handshake, draining layer 1 first.
// Revision 1.0
module mlp_weight_sequencer
  import mlp_weight_sequencer_pkg::*;
#(
  parameter int L1_NEURONS = 32,
  parameter int L2_NEURONS = 8,
  parameter int MAX_OUTST  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  w1_ready,
  input  logic                  b1_ready,
  input  logic                  w2_ready,
  input  logic                  b2_ready,
  output logic [W1_ADDR_W-1:0]  w1_address,
  output logic [B1_ADDR_W-1:0]  b1_address,
  output logic [W2_ADDR_W-1:0]  w2_address,
  output logic [B2_ADDR_W-1:0]  b2_address,
  output logic [BIAS_SEL_W-1:0] bias_sel,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output logic                  issue_layer,
  output logic                  issue_last,
  input  logic                  neuron_done,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam logic [W1_ADDR_W-1:0] L1_LAST = W1_ADDR_W'(L1_NEURONS - 1);
  localparam logic [W1_ADDR_W-1:0] L2_LAST = W1_ADDR_W'(L2_NEURONS - 1);

  state_t               state;
  logic [W1_ADDR_W-1:0] idx;
  logic [W1_ADDR_W-1:0] idx_nxt;
  logic [CNT_W-1:0]     outstanding;
  logic                 underflow;
  logic                 fire;
  logic                 all_ready;
  logic                 in_issue;
  logic                 in_run;
  logic                 abort;
  logic                 drained;

  assign all_ready   = w1_ready && b1_ready && w2_ready && b2_ready;
  assign in_issue    = (state == ST_L1_ISSUE) || (state == ST_L2_ISSUE);
  assign in_run      = in_issue || (state == ST_L1_DRAIN) || (state == ST_L2_DRAIN);
  assign abort       = in_run && !all_ready;
  assign issue_valid = in_issue && (outstanding < CNT_W'(MAX_OUTST));
  assign fire        = issue_valid && issue_ready;
  assign issue_last  = ((state == ST_L1_ISSUE) && (idx == L1_LAST)) ||
                       ((state == ST_L2_ISSUE) && (idx == L2_LAST));
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);
  assign idx_nxt     = idx + W1_ADDR_W'(1);
  assign drained     = (outstanding == '0) && !neuron_done;

  mlp_outstanding_counter #(
    .MAX (MAX_OUTST),
    .W   (CNT_W)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (abort),
    .inc       (fire),
    .dec       (neuron_done),
    .count     (outstanding),
    .underflow (underflow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      w1_address  <= '0;
      b1_address  <= '0;
      w2_address  <= '0;
      b2_address  <= '0;
      bias_sel    <= '0;
      issue_layer <= 1'b0;
      err         <= 1'b0;
    end else begin
      if (underflow || abort) err <= 1'b1;
      // A store losing its contents invalidates the whole inference.
      if (abort) begin
        state <= ST_IDLE;
        idx   <= '0;
      end else begin
        case (state)
          ST_IDLE: if (start) state <= ST_WAIT_RDY;
          ST_WAIT_RDY: if (all_ready) begin
            state       <= ST_L1_ISSUE;
            idx         <= '0;
            w1_address  <= '0;
            b1_address  <= '0;
            bias_sel    <= '0;
            issue_layer <= 1'b0;
          end
          ST_L1_ISSUE: if (fire) begin
            if (issue_last) begin
              state <= ST_L1_DRAIN;
              idx   <= '0;
            end else begin
              idx        <= idx_nxt;
              w1_address <= idx_nxt;
              b1_address <= idx_nxt[W1_ADDR_W-1 -: B1_ADDR_W];
              bias_sel   <= idx_nxt[BIAS_SEL_W-1:0];
            end
          end
          ST_L1_DRAIN: if (drained) begin
            state       <= ST_L2_ISSUE;
            w2_address  <= '0;
            b2_address  <= '0;
            bias_sel    <= '0;
            issue_layer <= 1'b1;
          end
          ST_L2_ISSUE: if (fire) begin
            if (issue_last) begin
              state <= ST_L2_DRAIN;
              idx   <= '0;
            end else begin
              idx        <= idx_nxt;
              w2_address <= idx_nxt[W2_ADDR_W-1:0];
              bias_sel   <= idx_nxt[BIAS_SEL_W-1:0];
            end
          end
          ST_L2_DRAIN: if (drained) state <= ST_DONE;
          ST_DONE:     state <= ST_IDLE;
          default:     state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mlp_weight_sequencer.sv
`default_nettype none
// tb_mlp_weight_sequencer: scenario tasks checking the sequencer against a job-list reference model.
// Revision 1.0
module tb_mlp_weight_sequencer;

  localparam int L1N  = 32;
  localparam int L2N  = 8;
  localparam int MAXO = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       w1_ready = 1'b0, b1_ready = 1'b0, w2_ready = 1'b0, b2_ready = 1'b0;
  logic       issue_ready = 1'b0;
  logic       neuron_done = 1'b0;
  logic [4:0] w1_address;
  logic [1:0] b1_address;
  logic [2:0] w2_address;
  logic [0:0] b2_address;
  logic [2:0] bias_sel;
  logic       issue_valid, issue_layer, issue_last, busy, done, err;

  int total = 0;
  int bad   = 0;

  mlp_weight_sequencer #(
    .L1_NEURONS (L1N),
    .L2_NEURONS (L2N),
    .MAX_OUTST  (MAXO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .w1_ready    (w1_ready),
    .b1_ready    (b1_ready),
    .w2_ready    (w2_ready),
    .b2_ready    (b2_ready),
    .w1_address  (w1_address),
    .b1_address  (b1_address),
    .w2_address  (w2_address),
    .b2_address  (b2_address),
    .bias_sel    (bias_sel),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_layer (issue_layer),
    .issue_last  (issue_last),
    .neuron_done (neuron_done),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic set_ready(input logic v);
    w1_ready = v; b1_ready = v; w2_ready = v; b2_ready = v;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; issue_ready = 1'b0; neuron_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns at a negedge with the DUT in WAIT_RDY.
  task automatic kick();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  function automatic logic [19:0] all_outs();
    return {w1_address, b1_address, w2_address, b2_address, bias_sel,
            issue_valid, issue_layer, issue_last, busy, done, err};
  endfunction

  // One inference; every accepted job is compared with the expected job list.
  task automatic run_inference(input bit rnd, output int done_pulses);
    int due_q[$];
    bit lay_q[$];
    int cyc = 0, done_cyc = -1, n_jobs = 0, outst = 0, l1_dones = 0, l2_dones = 0, last_due = 0;
    int e_addr, e_b, e_sel, o_addr, o_b, d, due;
    bit e_layer, e_last, lay;
    done_pulses = 0;
    kick();
    while (cyc < 4000 && !(done_cyc >= 0 && cyc >= done_cyc + 3)) begin
      issue_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      neuron_done = (due_q.size() > 0) && (due_q[0] <= cyc);
      #1;
      if (done) begin
        done_pulses++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        total++;
        if (busy !== 1'b0 || issue_valid !== 1'b0) begin
          bad++; $display("FAIL idle_after_done: busy=%b valid=%b want 0 0", busy, issue_valid);
        end
      end
      if (issue_valid && outst >= MAXO) begin
        total++; bad++;
        $display("FAIL outst_limit: valid=1 with %0d in flight, want valid=0", outst);
      end
      if (issue_valid && issue_ready) begin
        if (n_jobs < L1N) begin
          e_layer = 1'b0; e_addr = n_jobs; e_b = n_jobs / 8; e_sel = n_jobs % 8; e_last = (n_jobs == L1N - 1);
        end else begin
          e_layer = 1'b1; e_addr = n_jobs - L1N; e_b = 0; e_sel = (n_jobs - L1N) % 8; e_last = (n_jobs - L1N == L2N - 1);
        end
        o_addr = issue_layer ? int'(w2_address) : int'(w1_address);
        o_b    = issue_layer ? int'(b2_address) : int'(b1_address);
        total++;
        if (issue_layer !== e_layer || o_addr != e_addr || o_b != e_b || int'(bias_sel) != e_sel || issue_last !== e_last) begin
          bad++;
          $display("FAIL job%0d: got layer=%b addr=%0d bias_word=%0d sel=%0d last=%b want %b %0d %0d %0d %b",
                   n_jobs, issue_layer, o_addr, o_b, bias_sel, issue_last, e_layer, e_addr, e_b, e_sel, e_last);
        end
        if (e_layer && l1_dones != L1N) begin
          total++; bad++;
          $display("FAIL l2_early: layer-2 job with %0d layer-1 completions, want %0d", l1_dones, L1N);
        end
        d   = rnd ? int'($urandom_range(1, 6)) : 3;
        due = (cyc + d > last_due + 1) ? cyc + d : last_due + 1;
        last_due = due;
        due_q.push_back(due);
        lay_q.push_back(e_layer);
        n_jobs++; outst++;
      end
      if (neuron_done) begin
        void'(due_q.pop_front());
        lay = lay_q.pop_front();
        if (lay) l2_dones++; else l1_dones++;
        outst--;
      end
      @(negedge clk);
      cyc++;
    end
    neuron_done = 1'b0; issue_ready = 1'b0;
    total++;
    if (done_pulses != 1 || n_jobs != L1N + L2N || l2_dones != L2N) begin
      bad++;
      $display("FAIL inference: got done_pulses=%0d jobs=%0d l2_done=%0d want 1 %0d %0d", done_pulses, n_jobs, l2_dones, L1N + L2N, L2N);
    end
  endtask

  task automatic test_reset();
    set_ready(1'b0);
    do_reset();
    #1; total++;
    if (all_outs() !== 20'h0) begin bad++; $display("FAIL reset_outs: got %h want 0", all_outs()); end
    kick();
    repeat (3) @(negedge clk);
    #1; total++;
    if (busy !== 1'b1 || issue_valid !== 1'b0) begin
      bad++; $display("FAIL wait_rdy: busy=%b valid=%b want 1 0", busy, issue_valid);
    end
    set_ready(1'b1);
    @(negedge clk); #1; total++;
    if (issue_valid !== 1'b1 || w1_address !== 5'd0 || bias_sel !== 3'd0 || issue_layer !== 1'b0) begin
      bad++; $display("FAIL first_job: valid=%b w1=%0d sel=%0d layer=%b want 1 0 0 0", issue_valid, w1_address, bias_sel, issue_layer);
    end
  endtask

  task automatic test_full_run();
    int p;
    set_ready(1'b1);
    do_reset();
    run_inference(1'b0, p);
    #1; total++;
    if (err !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL full_run_end: err=%b busy=%b want 0 0", err, busy); end
  endtask

  task automatic test_back_to_back();
    int p;
    for (int i = 0; i < 2; i++) run_inference(1'b1, p);
    #1; total++;
    if (err !== 1'b0) begin bad++; $display("FAIL b2b_err: err=%b want 0", err); end
  endtask

  task automatic test_backpressure();
    int fired = 0, cyc = 0;
    bit prev = 1'b0, f;
    set_ready(1'b1);
    do_reset();
    kick();
    while (fired < 9 && cyc < 200) begin
      issue_ready = 1'b1; neuron_done = prev;
      #1; f = issue_valid && issue_ready; prev = f;
      if (f) fired++;
      @(negedge clk); cyc++;
    end
    issue_ready = 1'b0; neuron_done = prev;
    for (int i = 0; i < 5; i++) begin
      #1; total++;
      if (issue_valid !== 1'b1 || w1_address !== 5'd9 || b1_address !== 2'd1 || bias_sel !== 3'd1) begin
        bad++; $display("FAIL hold%0d: valid=%b w1=%0d b1=%0d sel=%0d want 1 9 1 1", i, issue_valid, w1_address, b1_address, bias_sel);
      end
      @(negedge clk); neuron_done = 1'b0;
    end
    issue_ready = 1'b1;
    @(negedge clk); issue_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1; total++;
      if (w1_address !== 5'd10 || b1_address !== 2'd1 || bias_sel !== 3'd2) begin
        bad++; $display("FAIL one_xfer%0d: w1=%0d b1=%0d sel=%0d want 10 1 2", i, w1_address, b1_address, bias_sel);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_max_outst();
    int fires = 0;
    set_ready(1'b1);
    do_reset();
    kick();
    issue_ready = 1'b1; neuron_done = 1'b0;
    repeat (6) begin
      #1; if (issue_valid) fires++;
      @(negedge clk);
    end
    #1; total++;
    if (fires != 2 || issue_valid !== 1'b0) begin
      bad++; $display("FAIL max_outst: transfers=%0d valid=%b want 2 0", fires, issue_valid);
    end
    neuron_done = 1'b1;
    @(negedge clk); #1; total++;
    if (issue_valid !== 1'b1) begin bad++; $display("FAIL reopen: valid=%b want 1", issue_valid); end
    @(negedge clk); neuron_done = 1'b0; #1; total++;
    if (issue_valid !== 1'b1 || w1_address !== 5'd3) begin
      bad++; $display("FAIL same_cycle: valid=%b w1=%0d want 1 3", issue_valid, w1_address);
    end
    @(negedge clk); #1; total++;
    if (issue_valid !== 1'b0 || w1_address !== 5'd4) begin
      bad++; $display("FAIL refill: valid=%b w1=%0d want 0 4", issue_valid, w1_address);
    end
    issue_ready = 1'b0;
  endtask

  task automatic test_spurious_done();
    int p;
    set_ready(1'b1);
    do_reset();
    @(negedge clk); neuron_done = 1'b1;
    @(negedge clk); neuron_done = 1'b0;
    #1; total++;
    if (err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL spurious: err=%b busy=%b want 1 0", err, busy); end
    run_inference(1'b0, p);
    #1; total++;
    if (err !== 1'b1) begin bad++; $display("FAIL err_sticky: err=%b want 1", err); end
    do_reset();
    #1; total++;
    if (err !== 1'b0) begin bad++; $display("FAIL err_clear: err=%b want 0", err); end
  endtask

  task automatic test_ready_drop();
    int pulses = 0;
    set_ready(1'b1);
    do_reset();
    kick();
    issue_ready = 1'b0;
    @(negedge clk); #1; total++;
    if (issue_valid !== 1'b1) begin bad++; $display("FAIL l1_issue: valid=%b want 1", issue_valid); end
    w2_ready = 1'b0;
    @(negedge clk); #1; total++;
    if (err !== 1'b1 || busy !== 1'b0 || issue_valid !== 1'b0) begin
      bad++; $display("FAIL ready_drop: err=%b busy=%b valid=%b want 1 0 0", err, busy, issue_valid);
    end
    set_ready(1'b1);
    repeat (5) begin
      if (done) pulses++;
      @(negedge clk); #1;
    end
    total++;
    if (pulses != 0) begin bad++; $display("FAIL no_done: pulses=%0d want 0", pulses); end
  endtask

  task automatic test_rst_mid();
    int cyc = 0;
    bit prev = 1'b0, stop = 1'b0, f;
    set_ready(1'b1);
    do_reset();
    kick();
    while (!stop && cyc < 500) begin
      issue_ready = 1'b1; neuron_done = prev;
      #1; f = issue_valid && issue_ready;
      if (f && issue_layer && issue_last) stop = 1'b1;
      prev = f;
      @(negedge clk); cyc++;
    end
    issue_ready = 1'b0; neuron_done = 1'b0;
    #1; total++;
    if (!stop || busy !== 1'b1 || issue_valid !== 1'b0 || issue_layer !== 1'b1) begin
      bad++; $display("FAIL l2_drain: reached=%b busy=%b valid=%b layer=%b want 1 1 0 1", stop, busy, issue_valid, issue_layer);
    end
    rst = 1'b1;
    #1; total++;
    if (all_outs() !== 20'h0) begin bad++; $display("FAIL async_rst: got %h want 0", all_outs()); end
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_back_to_back();
    test_backpressure();
    test_max_outst();
    test_spurious_done();
    test_ready_drop();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
